// File: rtl/flit_input_fifo_if.sv
// ---------------------------------------------------------------------------
// flit_input_fifo_if : upstream/downstream signal bundle for flit_input_fifo
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface flit_input_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_en;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] data_out;
  logic [2:0]            flit_id;
  logic [3:0]            dst_addr;
  logic                  frame_err;

  modport master (
    output valid_in, data_in, read_en,
    input  full, empty, data_out, flit_id, dst_addr, frame_err
  );

  modport slave (
    input  valid_in, data_in, read_en,
    output full, empty, data_out, flit_id, dst_addr, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/flit_input_fifo.sv
// ---------------------------------------------------------------------------
// flit_input_fifo : FWFT input buffer with packet-framing checker ahead of LBDR
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module flit_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  wire               clk,
  input  wire               rst,
  flit_input_fifo_if.slave  flit_if
);

  localparam logic [2:0] c_header = 3'b001;
  localparam logic [2:0] c_body   = 3'b010;
  localparam logic [2:0] c_tail   = 3'b100;

  localparam logic [0:0] c_st_idle   = 1'b0;
  localparam logic [0:0] c_st_in_pkt = 1'b1;

  localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] c_one   = (PTR_W+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [0:0]            state_q, state_d;
  logic                  frame_err_q, frame_err_d;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_cand;
  logic                  w_wr;
  logic                  w_pop;
  logic [2:0]            w_code;

  assign w_full  = (count_q == c_depth);
  assign w_empty = (count_q == '0);
  assign w_cand  = flit_if.valid_in && !w_full;
  assign w_pop   = flit_if.read_en && !w_empty;
  assign w_code  = flit_if.data_in[DATA_WIDTH-1 -: 3];

  // Framing check only looks at flits that would otherwise be accepted.
  always_comb begin
    w_wr        = 1'b0;
    state_d     = state_q;
    frame_err_d = 1'b0;
    if (w_cand) begin
      if (state_q == c_st_idle) begin
        if (w_code == c_header) begin
          w_wr    = 1'b1;
          state_d = c_st_in_pkt;
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        if (w_code == c_body) begin
          w_wr = 1'b1;
        end else if (w_code == c_tail) begin
          w_wr    = 1'b1;
          state_d = c_st_idle;
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (w_wr && !w_pop) begin
      count_d = count_q + c_one;
    end else if (!w_wr && w_pop) begin
      count_d = count_q - c_one;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= c_st_idle;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (rst && w_wr) begin
      mem_q[wr_ptr_q] <= flit_if.data_in;
    end
  end

  assign flit_if.full      = w_full;
  assign flit_if.empty     = w_empty;
  assign flit_if.data_out  = mem_q[rd_ptr_q];
  assign flit_if.flit_id   = mem_q[rd_ptr_q][DATA_WIDTH-1 -: 3];
  assign flit_if.dst_addr  = mem_q[rd_ptr_q][3:0];
  assign flit_if.frame_err = frame_err_q;

endmodule

`default_nettype wire
